// File: rtl/alu_seq_if.sv
// Handshake bus for alu_seq: operand/opcode request channel plus registered result channel.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUCtl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             Illegal;

  modport master (
    output InValid, A, B, ALUCtl, OutReady,
    input  InReady, OutValid, ALUOut, Zero, Illegal
  );

  modport slave (
    input  InValid, A, B, ALUCtl, OutReady,
    output InReady, OutValid, ALUOut, Zero, Illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus optional multi-cycle MUL/DIVU/REMU.
// Define ALU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module alu_seq #(
  parameter int unsigned WIDTH = 64
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSlt  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpXor  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OpMul  = 4'b1001;
  localparam logic [3:0] OpDivu = 4'b1010;
  localparam logic [3:0] OpRemu = 4'b1011;

  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StDone = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StDone = 2'd2} state_e;
`endif

  state_e state_q, state_d, issue_state;

  logic             in_ready;
  logic             hs;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;

  logic             res_load;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  logic             zero_q;
  logic             illegal_q;

  assign hs           = bus.InValid & in_ready;
  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid_q;
  assign bus.ALUOut   = alu_out_q;
  assign bus.Zero     = zero_q;
  assign bus.Illegal  = illegal_q;

  // Single-cycle result, computed straight from the presented operands.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (bus.ALUCtl)
      OpAnd:   sc_res = bus.A & bus.B;
      OpOr:    sc_res = bus.A | bus.B;
      OpAdd:   sc_res = bus.A + bus.B;
      OpSub:   sc_res = bus.A - bus.B;
      OpXor:   sc_res = bus.A ^ bus.B;
      OpSlt:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OpSll:   sc_res = bus.A << bus.B[SHW-1:0];
      OpSrl:   sc_res = bus.A >> bus.B[SHW-1:0];
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             multi_op;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] mc_res;
  logic             last_iter;

  assign multi_op = (bus.ALUCtl == OpMul) || (bus.ALUCtl == OpDivu) || (bus.ALUCtl == OpRemu);

  // MUL: acc += opa when opb[0]; opa shifts up, opb shifts down.
  // DIVU/REMU: acc is the partial remainder, opa shifts dividend out and quotient in.
  // A zero divisor always subtracts, which yields all-ones quotient and remainder = A.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    last_iter = (cnt_d == CW'(WIDTH));
    rem_sh    = {acc_q, opa_q[WIDTH-1]};
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    if (op_q == OpMul) begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else if (rem_sh >= {1'b0, opb_q}) begin
      acc_d = rem_sh[WIDTH-1:0] - opb_q;
      opa_d = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_sh[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], 1'b0};
    end
    mc_res = (op_q == OpDivu) ? opa_d : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      op_q  <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (hs && multi_op) begin
      cnt_q <= '0;
      op_q  <= bus.ALUCtl;
      acc_q <= '0;
      opa_q <= bus.A;
      opb_q <= bus.B;
    end else if (state_q == StExec) begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end
`endif

  // Result register update: single-cycle ops at the handshake, multi-cycle on the last iteration.
  always_comb begin
    res_load = hs;
    res_d    = sc_res;
    ill_d    = sc_ill;
`ifdef ALU_MULDIV_EN
    if (hs && multi_op) begin
      res_load = 1'b0;
    end
    if ((state_q == StExec) && last_iter) begin
      res_load = 1'b1;
      res_d    = mc_res;
      ill_d    = 1'b0;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
`ifdef ALU_MULDIV_EN
    issue_state = multi_op ? StExec : StDone;
`else
    issue_state = StDone;
`endif
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (hs) state_d = issue_state;
      end
`ifdef ALU_MULDIV_EN
      StExec: begin
        if (last_iter) state_d = StDone;
      end
`endif
      StDone: begin
        if (bus.OutReady) state_d = hs ? issue_state : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StDone:  in_ready = bus.OutReady;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_d == StDone);
      if (res_load) begin
        alu_out_q <= res_d;
        zero_q    <= (res_d == '0);
        illegal_q <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hold/back-to-back and reset sequences,
// then random operations against a plain-arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W      = 64;
  localparam int          MC_LAT = W + 1;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
    return MD && (op == 4'd9 || op == 4'd10 || op == 4'd11);
  endfunction

  // Reference behaviour from the opcode table, using plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic ill);
    ill = 1'b0;
    r   = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd6: r = a - b;
      4'd7: r = a ^ b;
      4'd4: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd3: r = a << b[5:0];
      4'd8: r = a >> b[5:0];
      default: begin
        if (is_md(op)) begin
          if (op == 4'd9)       r = a * b;
          else if (op == 4'd10) r = (b == 0) ? {64{1'b1}} : a / b;
          else                  r = (b == 0) ? a : a % b;
        end else begin
          ill = 1'b1;
        end
      end
    endcase
  endfunction

  task automatic add_vec(input string name, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic zero,
                         input logic ill, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.res = res; v.zero = zero; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Presents an operation and returns just after its handshake edge; inputs are then scrambled.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit ok;
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.ALUCtl  = op;
    bus.A       = a;
    bus.B       = b;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.InReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("handshake_ready", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    bus.A       = ~a;
    bus.B       = ~b;
    bus.ALUCtl  = ~op;
  endtask

  task automatic wait_result(output int lat, output int ready_viol);
    lat        = 1;
    ready_viol = 0;
    while (!bus.OutValid && lat < 200) begin
      if (bus.InReady !== 1'b0) ready_viol++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] res, input logic zero,
                               input logic ill, input int lat);
    int got_lat, viol;
    issue(op, a, b);
    wait_result(got_lat, viol);
    check($sformatf("%s.latency", name), 64'(got_lat), 64'(lat));
    check($sformatf("%s.ALUOut", name), bus.ALUOut, res);
    check($sformatf("%s.Zero", name), 64'(bus.Zero), 64'(zero));
    check($sformatf("%s.Illegal", name), 64'(bus.Illegal), 64'(ill));
    if (lat > 1) check($sformatf("%s.exec_inready", name), 64'(viol), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, viol, ov_seen;
    logic [3:0]  op;
    logic [63:0] a, b, r;
    logic        ill;
    logic [63:0] held;

    bus.InValid  = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.ALUCtl   = '0;
    bus.OutReady = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("reset.InReady", 64'(bus.InReady), 64'd1);
    check("reset.OutValid", 64'(bus.OutValid), 64'd0);
    check("reset.ALUOut", bus.ALUOut, 64'd0);
    check("reset.Zero", 64'(bus.Zero), 64'd0);
    check("reset.Illegal", 64'(bus.Illegal), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    add_vec("add", 4'b0010, 64'd10, 64'd5, 64'd15, 1'b0, 1'b0, 1);
    add_vec("sub_zero", 4'b0110, 64'd100, 64'd100, 64'd0, 1'b1, 1'b0, 1);
    add_vec("slt_neg", 4'b0100, -64'sd5, 64'd10, 64'd1, 1'b0, 1'b0, 1);
    add_vec("slt_false", 4'b0100, 64'd20, 64'd5, 64'd0, 1'b1, 1'b0, 1);
    add_vec("srl", 4'b1000, 64'd64, 64'd2, 64'd16, 1'b0, 1'b0, 1);
    add_vec("sll_wrapamt", 4'b0011, 64'd1, 64'd67, 64'd8, 1'b0, 1'b0, 1);
    add_vec("xor", 4'b0111, 64'hAA, 64'h55, 64'hFF, 1'b0, 1'b0, 1);
    add_vec("or", 4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1);
    add_vec("add_wrap", 4'b0010, {64{1'b1}}, 64'd1, 64'd0, 1'b1, 1'b0, 1);
    add_vec("illegal_f", 4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 1);
    add_vec("illegal_5", 4'b0101, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 1);
`ifdef ALU_MULDIV_EN
    add_vec("mul", 4'b1001, 64'd12345, 64'd678, 64'd8369910, 1'b0, 1'b0, MC_LAT);
    add_vec("divu", 4'b1010, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, MC_LAT);
    add_vec("remu", 4'b1011, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, MC_LAT);
    add_vec("divu_by0", 4'b1010, 64'd9, 64'd0, {64{1'b1}}, 1'b0, 1'b0, MC_LAT);
    add_vec("remu_by0", 4'b1011, 64'd9, 64'd0, 64'd9, 1'b0, 1'b0, MC_LAT);
`else
    add_vec("mul_off", 4'b1001, 64'd12345, 64'd678, 64'd0, 1'b1, 1'b1, 1);
    add_vec("divu_off", 4'b1010, 64'd100, 64'd7, 64'd0, 1'b1, 1'b1, 1);
    add_vec("remu_off", 4'b1011, 64'd100, 64'd7, 64'd0, 1'b1, 1'b1, 1);
`endif

    foreach (vecs[i]) begin
      run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                    vecs[i].zero, vecs[i].ill, vecs[i].lat);
    end

    // Hold a result with OutReady low, then release with a back-to-back AND.
    issue(4'b0010, 64'd7, 64'd8);
    bus.OutReady = 1'b0;
    wait_result(lat, viol);
    check("hold.first", bus.ALUOut, 64'd15);
    held = bus.ALUOut;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold.ALUOut[%0d]", i), bus.ALUOut, held);
      check($sformatf("hold.InReady[%0d]", i), 64'(bus.InReady), 64'd0);
      check($sformatf("hold.OutValid[%0d]", i), 64'(bus.OutValid), 64'd1);
    end
    bus.OutReady = 1'b1;
    bus.InValid  = 1'b1;
    bus.ALUCtl   = 4'b0000;
    bus.A        = 64'hFF;
    bus.B        = 64'h0F;
    #1;
    check("b2b.InReady", 64'(bus.InReady), 64'd1);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    check("b2b.ALUOut", bus.ALUOut, 64'h0F);
    check("b2b.OutValid", 64'(bus.OutValid), 64'd1);

    // Reset in the middle of a MUL discards it.
    issue(4'b1001, 64'd12345, 64'd678);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.OutValid", 64'(bus.OutValid), 64'd0);
    check("midreset.InReady", 64'(bus.InReady), 64'd1);
    check("midreset.ALUOut", bus.ALUOut, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < MC_LAT + 10; i++) begin
      @(negedge clk);
      if (bus.OutValid) ov_seen++;
    end
    check("midreset.no_result", 64'(ov_seen), 64'd0);
    run_and_check("post_reset_add", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 20));
      else                           b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(0, 50));
      model(op, a, b, r, ill);
      run_and_check($sformatf("rand%0d_op%0h", n, op), op, a, b, r, (r == 0), ill,
                    is_md(op) ? MC_LAT : 1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 64-bit combinational ALU. Keeps the existing ALUCtl encodings and adds multi-cycle unsigned multiply, divide and remainder. Operands are captured on a valid/ready handshake and the result is held until the consumer accepts it. Sits between the register-read stage and writeback; the datapath controller stalls issue on InReady.

## Interface
- WIDTH, 64: operand and result width in bits; must be a power of two and at least 8. SHW = log2(WIDTH) is derived internally.

- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- InValid  in  1  operands and opcode presented
- InReady  out  1  block can accept an operation
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALUCtl  in  4  opcode
- OutValid  out  1  result registers hold an unconsumed result
- OutReady  in  1  consumer accepts the result
- ALUOut  out  WIDTH  registered result
- Zero  out  1  registered; 1 when ALUOut == 0
- Illegal  out  1  registered; 1 when the opcode was not recognised

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 XOR.
  - 0100 SLT: signed compare; result is 1 when A < B, else 0.
  - 0011 SLL and 1000 SRL: logical shifts by B[SHW-1:0]; the upper bits of B are ignored.
  - 1001 MUL: low WIDTH bits of A*B, unsigned.
  - 1010 DIVU: unsigned quotient. 1011 REMU: unsigned remainder.
- Arithmetic wraps modulo 2^WIDTH. No overflow or carry flag is produced.
- Divide by zero: DIVU returns all-ones and REMU returns A. No flag is raised.
- Any other opcode: ALUOut = 0, Zero = 1, Illegal = 1. Illegal opcodes take the single-cycle path.
- A handshake is InValid && InReady at a rising edge. A, B and ALUCtl are latched at the handshake; later changes to the inputs have no effect.
- States:
  - IDLE: InReady = 1.
  - EXEC: multi-cycle operation in progress; InReady = 0.
  - DONE: OutValid = 1; InReady = OutReady.
- Transitions:
  - IDLE, handshake with a single-cycle opcode → DONE.
  - IDLE, handshake with MUL/DIVU/REMU → EXEC.
  - EXEC, iteration counter reaches WIDTH → DONE.
  - DONE, OutReady = 1 with no new handshake → IDLE.
  - DONE, OutReady = 1 with a new handshake → DONE or EXEC, depending on the new opcode (back-to-back issue).
  - DONE, OutReady = 0 → DONE.
- MUL is shift-add, one partial-product bit per cycle. DIVU/REMU is restoring division, one quotient bit per cycle. Each runs WIDTH iterations.
- While in DONE with OutReady = 0, ALUOut, Zero and Illegal stay stable and no new operation is accepted.

## Timing
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; iteration counter = 0.
  - OutValid = 0, ALUOut = 0, Zero = 0, Illegal = 0.
  - InReady reads 1 while in reset.
- Latency, measured from the handshake edge to the first edge at which OutValid = 1:
  - single-cycle ops: 1 cycle;
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Throughput:
  - single-cycle ops: 1 per cycle while OutReady is held at 1;
  - multi-cycle ops: 1 per WIDTH+1 cycles.
- Reset asserted mid-EXEC or in DONE: the operation is discarded and no result is delivered. After release the block behaves as freshly reset.
- OutValid, ALUOut, Zero and Illegal are driven only from flops. InReady is combinational from state and OutReady.

## Configuration
- ALU_MULDIV_EN defined: the MUL/DIVU/REMU datapath, the iteration counter and the EXEC state are compiled in.
- ALU_MULDIV_EN undefined:
  - the MUL/DIVU/REMU datapath, iteration counter and EXEC state are removed;
  - opcodes 1001, 1010 and 1011 are treated as illegal (ALUOut = 0, Zero = 1, Illegal = 1, latency 1);
  - all other behaviour is unchanged.

## Test plan
- WIDTH = 64, OutReady held at 1:
  - ADD A=10, B=5 → ALUOut = 15, Zero = 0, OutValid exactly 1 cycle after the handshake.
  - SUB A=100, B=100 → ALUOut = 0, Zero = 1.
- SLT A=-5, B=10 → 1; SLT A=20, B=5 → 0; SRL A=64, B=2 → 16; SLL A=1, B=67 → 8 (shift amount 3); XOR 0xAA, 0x55 → 0xFF.
- With ALU_MULDIV_EN defined:
  - MUL A=12345, B=678 → ALUOut = 8369910; OutValid 65 cycles after the handshake; InReady = 0 throughout EXEC.
- With ALU_MULDIV_EN defined:
  - DIVU 100/7 → 14; REMU 100/7 → 2;
  - DIVU A=9, B=0 → 0xFFFF_FFFF_FFFF_FFFF; REMU A=9, B=0 → 9.
- Hold and back-to-back:
  - OutReady = 0 for 3 cycles after an ADD result → ALUOut held stable and InReady = 0.
  - Then OutReady = 1 with InValid = 1 (AND 0xFF, 0x0F) → the next cycle shows ALUOut = 0x0F.
- Illegal and reset:
  - ALUCtl = 1111 → Illegal = 1, ALUOut = 0, Zero = 1.
  - rst_n pulsed low 10 cycles into a MUL → OutValid = 0 immediately and stays 0. A following ADD 2+3 returns 5.
